dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port of the pipelined RISC-V core between the core's load/store stage and a secondary DMA/debug requester. Each requester gets a request/done handshake. The block serializes accesses, drives the memory-side `MemWrite`/`DataAdr`/`WriteData` signals, and stalls the pipeline while a core access is pending. It sits between the MEM stage of the pipeline and the data memory inside `top`.

## Interface
Parameters:
- `MEM_LAT`, default 2: memory access latency in cycles. Legal range 1..4.
- `STARVE_LIMIT`, default 3: consecutive DMA losses before DMA is forced a grant. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_req`  in  1  core access request; held high until `core_done`.
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  32  byte address.
- `core_wdata`  in  32  store data.
- `core_rdata`  out  32  load result; valid while `core_done`=1.
- `core_done`  out  1  one-cycle completion pulse.
- `core_stall`  out  1  pipeline stall; equals `core_req & ~core_done`.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_done`  same directions, widths and meanings as the core_* ports, for the DMA requester.
- `grant_dma`  out  1  1 while the current BUSY/DONE access belongs to DMA.
- `MemWrite`  out  1  memory write strobe.
- `DataAdr`  out  32  memory address.
- `WriteData`  out  32  memory write data.
- `ReadData`  in  32  memory read data, valid in the last BUSY cycle.

## Operation
- The FSM has three states.
  - **IDLE.** Samples the requests. If neither requester is asking, it stays in IDLE. Otherwise it selects a winner, latches that winner's we/addr/wdata into registers, and moves to BUSY.
  - **BUSY.** Lasts exactly `MEM_LAT` cycles, tracked by a down-counter loaded with `MEM_LAT-1`. `DataAdr`/`WriteData` are held stable for the whole of BUSY. `MemWrite` is 1 only in the first BUSY cycle, and only for a store. On the edge ending the cycle where the counter is 0: `ReadData` is captured into the winner's rdata register for a load (a store leaves rdata unchanged), and the FSM moves to DONE.
  - **DONE.** One cycle. The winner's done pulse is 1. Requests are ignored in this cycle, so a still-high req cannot re-grant. Next state is IDLE.
- **Arbitration.** The core has fixed priority.
  - A starvation counter increments on each IDLE decision where `dma_req`=1 and the core wins.
  - When the counter equals `STARVE_LIMIT`, the next IDLE decision with `dma_req`=1 goes to DMA, even if `core_req`=1.
  - The counter clears on any DMA grant, and in any IDLE cycle with `dma_req`=0.
- **Output defaults.** `DataAdr`/`WriteData` keep their last value outside BUSY. `MemWrite` is 0 outside the first BUSY cycle.
- **Request changes mid-access.** A req dropped during BUSY does not abort the access. The access completes and the done pulse is still issued.

## Timing
- **Reset.** All outputs 0, the state is IDLE, and the starvation counter is 0. Reset takes effect on the next edge from any state. An access interrupted by reset issues no done pulse.
- **Latency.** A req first high in IDLE cycle t gives:
  - MemWrite in cycle t+1;
  - ReadData sampled at the end of cycle t+`MEM_LAT`;
  - done in cycle t+`MEM_LAT`+1.
- **Throughput.** One access per `MEM_LAT`+2 cycles for back-to-back requests.
- `core_stall` is combinational from `core_req` and the registered `core_done`. There is no path from `ReadData` to any output.
- **Simultaneous requests** with the starvation counter below the limit: the core wins. DMA is served at the next IDLE.

## Configuration
- `DMEM_ARB_STARVE_EN`
  - **Defined:** the starvation counter and forced DMA grant are present, as described in Operation.
  - **Undefined:** pure fixed core priority, and `STARVE_LIMIT` is unused. DMA can starve indefinitely under continuous core traffic.

## Test plan
All scenarios use `MEM_LAT`=2 and `STARVE_LIMIT`=3.
- **Core store.** `core_req`=1, we=1, addr=100, wdata=25 at cycle 0 → `MemWrite`=1 with `DataAdr`=100 and `WriteData`=25 in cycle 1 only; `core_done` in cycle 3; `core_stall`=1 in cycles 0–2.
- **Core load.** addr=96, `ReadData`=0x00001234 in cycle 2 → `core_rdata`=0x00001234 and `core_done`=1 in cycle 3; `MemWrite` stays 0 throughout.
- **Simultaneous requests.** Both req high at cycle 0 → core done in cycle 3, `grant_dma`=1 in cycles 5–7, `dma_done` in cycle 7, `core_stall`=0 from cycle 3.
- **Starvation, macro defined.** `core_req` and `dma_req` held high, with each requester raising req again in the cycle after its done pulse → core wins decisions 1–3, DMA wins decision 4, and the starvation counter is 0 after it.
- **Starvation, macro undefined.** Same stimulus → `dma_done` never asserts over 20 core accesses.
- **Reset mid-access.** `reset`=1 during the BUSY cycle 1 of a store → in cycle 2 all outputs are 0 and the state is IDLE; no done pulse follows.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/done handshakes for core and DMA plus the shared data-memory port.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        core_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic        grant_dma;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ReadData,
    output core_rdata, core_done, core_stall,
    output dma_rdata, dma_done, grant_dma,
    output MemWrite, DataAdr, WriteData
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ReadData,
    input  core_rdata, core_done, core_stall,
    input  dma_rdata, dma_done, grant_dma,
    input  MemWrite, DataAdr, WriteData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serializes core and DMA accesses onto one data-memory port, core has priority.
// Define DMEM_ARB_STARVE_EN to force a DMA grant after STARVE_LIMIT consecutive DMA losses.
module dmem_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 3
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t     state, state_n;
  logic [1:0] cnt;
  logic       win_dma, we_r, any_req, pick_dma;
  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("dmem_arbiter: parameter out of range");
  end
  assign any_req = bus.core_req | bus.dma_req;
`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] starve;
  assign pick_dma = bus.dma_req & (~bus.core_req | (starve == 4'(STARVE_LIMIT)));
  // any IDLE cycle that does not hand DMA a loss clears the count
  always_ff @(posedge clk)
    if (reset) starve <= '0;
    else if (state == IDLE) starve <= (bus.dma_req & ~pick_dma) ? starve + 4'd1 : '0;
`else
  assign pick_dma = bus.dma_req & ~bus.core_req;
`endif
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (any_req ? BUSY : IDLE) :
              (state == BUSY) ? ((cnt == 2'd0) ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    bus.MemWrite  = 1'b0;
    bus.core_done = 1'b0;
    bus.dma_done  = 1'b0;
    bus.grant_dma = 1'b0;
    bus.MemWrite  = (state == BUSY) && (cnt == 2'(MEM_LAT - 1)) && we_r;
    bus.core_done = (state == DONE) && !win_dma;
    bus.dma_done  = (state == DONE) && win_dma;
    bus.grant_dma = (state != IDLE) && win_dma;
  end
  assign bus.core_stall = bus.core_req & ~bus.core_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      win_dma        <= 1'b0;
      we_r           <= 1'b0;
      bus.DataAdr    <= '0;
      bus.WriteData  <= '0;
      bus.core_rdata <= '0;
      bus.dma_rdata  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        win_dma       <= pick_dma;
        we_r          <= pick_dma ? bus.dma_we : bus.core_we;
        bus.DataAdr   <= pick_dma ? bus.dma_addr : bus.core_addr;
        bus.WriteData <= pick_dma ? bus.dma_wdata : bus.core_wdata;
        cnt           <= 2'(MEM_LAT - 1);
      end
      if (state == BUSY) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd0 && !we_r && win_dma) bus.dma_rdata <= bus.ReadData;
        if (cnt == 2'd0 && !we_r && !win_dma) bus.core_rdata <= bus.ReadData;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int L  = 2;
  localparam int SL = 3;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  dmem_arbiter_if bus();
  dmem_arbiter #(.MEM_LAT(L), .STARVE_LIMIT(SL)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic quiet;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dma_req  = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr  = '0; bus.dma_wdata  = '0;
    bus.ReadData = '0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    quiet();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    quiet();
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({bus.MemWrite, bus.grant_dma, bus.core_done, bus.dma_done, bus.core_stall} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000",
        {bus.MemWrite, bus.grant_dma, bus.core_done, bus.dma_done, bus.core_stall});
    end
    total++;
    if ({bus.DataAdr, bus.WriteData} !== 64'd0) begin
      bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", bus.DataAdr, bus.WriteData);
    end
    total++;
    if ({bus.core_rdata, bus.dma_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.core_rdata, bus.dma_rdata);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_core_store;
    do_reset();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'd100; bus.core_wdata = 32'd25;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) bus.core_req = 1'b0;
      @(negedge clk);
      total++;
      if (bus.MemWrite !== (c == 1)) begin
        bad++; $display("FAIL store_memwrite c=%0d got=%b exp=%b", c, bus.MemWrite, c == 1);
      end
      if (c == 1 || c == 2) begin
        total++;
        if (bus.DataAdr !== 32'd100 || bus.WriteData !== 32'd25) begin
          bad++; $display("FAIL store_bus c=%0d got=%0d/%0d exp=100/25", c, bus.DataAdr, bus.WriteData);
        end
      end
      total++;
      if (bus.core_done !== (c == 3)) begin
        bad++; $display("FAIL store_done c=%0d got=%b exp=%b", c, bus.core_done, c == 3);
      end
      total++;
      if (bus.core_stall !== (c < 3)) begin
        bad++; $display("FAIL store_stall c=%0d got=%b exp=%b", c, bus.core_stall, c < 3);
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_core_load;
    do_reset();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'd96;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) bus.core_req = 1'b0;
      bus.ReadData = (c == 2) ? 32'h0000_1234 : $urandom;
      @(negedge clk);
      total++;
      if (bus.MemWrite !== 1'b0) begin
        bad++; $display("FAIL load_memwrite c=%0d got=%b exp=0", c, bus.MemWrite);
      end
      total++;
      if (bus.core_done !== (c == 3)) begin
        bad++; $display("FAIL load_done c=%0d got=%b exp=%b", c, bus.core_done, c == 3);
      end
      if (c == 3) begin
        total++;
        if (bus.core_rdata !== 32'h0000_1234) begin
          bad++; $display("FAIL load_rdata got=%h exp=00001234", bus.core_rdata);
        end
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_simultaneous;
    do_reset();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'd8;   bus.core_wdata = 32'h77;
    bus.dma_req  = 1'b1; bus.dma_we  = 1'b0; bus.dma_addr  = 32'd200;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) bus.core_req = 1'b0;
      if (c == 8) bus.dma_req = 1'b0;
      bus.ReadData = (c == 6) ? 32'hABCD_0001 : $urandom;
      @(negedge clk);
      total++;
      if (bus.core_done !== (c == 3)) begin
        bad++; $display("FAIL sim_core_done c=%0d got=%b exp=%b", c, bus.core_done, c == 3);
      end
      total++;
      if (bus.dma_done !== (c == 7)) begin
        bad++; $display("FAIL sim_dma_done c=%0d got=%b exp=%b", c, bus.dma_done, c == 7);
      end
      total++;
      if (bus.grant_dma !== (c >= 5 && c <= 7)) begin
        bad++; $display("FAIL sim_grant c=%0d got=%b exp=%b", c, bus.grant_dma, c >= 5 && c <= 7);
      end
      total++;
      if (bus.core_stall !== (c < 3)) begin
        bad++; $display("FAIL sim_stall c=%0d got=%b exp=%b", c, bus.core_stall, c < 3);
      end
      if (c == 7) begin
        total++;
        if (bus.dma_rdata !== 32'hABCD_0001) begin
          bad++; $display("FAIL sim_dma_rdata got=%h exp=abcd0001", bus.dma_rdata);
        end
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_starvation;
    bit dn, dm;
    do_reset();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h10;
    bus.dma_req  = 1'b1; bus.dma_we  = 1'b0; bus.dma_addr  = 32'h20;
    for (int c = 0; c < 20 * (L + 2); c++) begin
      dn = (c % (L + 2)) == L + 1;
      dm = SEN && ((c / (L + 2)) % (SL + 1)) == SL;
      @(negedge clk);
      total++;
      if (bus.core_done !== (dn && !dm)) begin
        bad++; $display("FAIL starve_core_done c=%0d got=%b exp=%b", c, bus.core_done, dn && !dm);
      end
      total++;
      if (bus.dma_done !== (dn && dm)) begin
        bad++; $display("FAIL starve_dma_done c=%0d got=%b exp=%b", c, bus.dma_done, dn && dm);
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_reset_mid_access;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h0ABC; bus.core_wdata = 32'h5555;
      end
      if (c == 1) reset = 1'b1;
      if (c == 2) begin reset = 1'b0; bus.core_req = 1'b0; end
      if (c == 7) begin bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h40; end
      if (c == 11) bus.core_req = 1'b0;
      bus.ReadData = (c == 9) ? 32'hCAFE_0001 : $urandom;
      @(negedge clk);
      if (c == 2) begin
        total++;
        if ({bus.MemWrite, bus.grant_dma, bus.core_done, bus.dma_done, bus.core_stall,
             bus.DataAdr, bus.WriteData, bus.core_rdata, bus.dma_rdata} !== '0) begin
          bad++; $display("FAIL midrst_zero mw=%b adr=%h wd=%h crd=%h drd=%h",
            bus.MemWrite, bus.DataAdr, bus.WriteData, bus.core_rdata, bus.dma_rdata);
        end
      end
      if (c >= 2) begin
        total++;
        if ({bus.core_done, bus.dma_done, bus.MemWrite} !== {c == 10, 2'b00}) begin
          bad++; $display("FAIL midrst_done c=%0d got=%b exp=%b", c,
            {bus.core_done, bus.dma_done, bus.MemWrite}, {c == 10, 2'b00});
        end
      end
      if (c == 8) begin
        total++;
        if (bus.DataAdr !== 32'h40) begin
          bad++; $display("FAIL midrst_adr got=%h exp=00000040", bus.DataAdr);
        end
      end
      if (c == 10) begin
        total++;
        if (bus.core_rdata !== 32'hCAFE_0001) begin
          bad++; $display("FAIL midrst_rdata got=%h exp=cafe0001", bus.core_rdata);
        end
      end
      next_cycle();
    end
    quiet();
  endtask

  // Model tracks one access at a time: decision cycle d, busy d+1..d+L, done d+L+1.
  task automatic test_random;
    int nd = 0, d = 0, starve = 0;
    bit act = 1'b0, cdma = 1'b0, cwe = 1'b0, pcd = 1'b0, pdd = 1'b0, pbusy = 1'b0;
    bit ib, idn, emw, egd, ecd, edd, dw;
    logic [31:0] caddr = '0, cwd = '0, la = '0, lw = '0, ecr = '0, edr = '0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (pcd) begin
        bus.core_req = 1'($urandom_range(0, 1)); bus.core_we = 1'($urandom_range(0, 1));
        bus.core_addr = $urandom; bus.core_wdata = $urandom;
      end else if (!bus.core_req && $urandom_range(0, 3) == 0) begin
        bus.core_req = 1'b1; bus.core_we = 1'($urandom_range(0, 1));
        bus.core_addr = $urandom; bus.core_wdata = $urandom;
      end else if (pbusy && !cdma && bus.core_req && $urandom_range(0, 7) == 0) bus.core_req = 1'b0;
      if (pdd) begin
        bus.dma_req = 1'($urandom_range(0, 1)); bus.dma_we = 1'($urandom_range(0, 1));
        bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
      end else if (!bus.dma_req && $urandom_range(0, 4) == 0) begin
        bus.dma_req = 1'b1; bus.dma_we = 1'($urandom_range(0, 1));
        bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
      end
      bus.ReadData = (act && c == d + L) ? hash(caddr) : $urandom;
      @(negedge clk);
      ib  = act && c > d && c <= d + L;
      idn = act && c == d + L + 1;
      if (idn && !cwe && cdma) edr = hash(caddr);
      if (idn && !cwe && !cdma) ecr = hash(caddr);
      emw = ib && c == d + 1 && cwe;
      egd = (ib || idn) && cdma;
      ecd = idn && !cdma;
      edd = idn && cdma;
      total++;
      if (bus.MemWrite !== emw) begin
        bad++; $display("FAIL rnd_memwrite c=%0d got=%b exp=%b", c, bus.MemWrite, emw);
      end
      total++;
      if (bus.DataAdr !== la || bus.WriteData !== lw) begin
        bad++; $display("FAIL rnd_bus c=%0d got=%h/%h exp=%h/%h", c, bus.DataAdr, bus.WriteData, la, lw);
      end
      total++;
      if (bus.grant_dma !== egd) begin
        bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, bus.grant_dma, egd);
      end
      total++;
      if ({bus.core_done, bus.dma_done} !== {ecd, edd}) begin
        bad++; $display("FAIL rnd_done c=%0d got=%b%b exp=%b%b", c, bus.core_done, bus.dma_done, ecd, edd);
      end
      total++;
      if (bus.core_rdata !== ecr || bus.dma_rdata !== edr) begin
        bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, bus.core_rdata, bus.dma_rdata, ecr, edr);
      end
      total++;
      if (bus.core_stall !== (bus.core_req && !ecd)) begin
        bad++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, bus.core_stall, bus.core_req && !ecd);
      end
      if (c >= nd) begin
        dw = bus.dma_req && (!bus.core_req || (SEN && starve == SL));
        if (bus.core_req || bus.dma_req) begin
          act   = 1'b1;
          d     = c;
          nd    = c + L + 2;
          cdma  = dw;
          cwe   = dw ? bus.dma_we : bus.core_we;
          caddr = dw ? bus.dma_addr : bus.core_addr;
          cwd   = dw ? bus.dma_wdata : bus.core_wdata;
          la    = caddr;
          lw    = cwd;
        end
        starve = (bus.dma_req && !dw) ? starve + 1 : 0;
      end
      pcd   = ecd;
      pdd   = edd;
      pbusy = ib;
      next_cycle();
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_core_store();
    test_core_load();
    test_simultaneous();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
